ps_seq: RTL and testbench
=========================

Name: ps_seq

Overview:
- Multi-cycle, area-scalable ASCON substitution layer (pS).
- Applies the 5-bit ASCON S-box to all 64 bit-columns of a 320-bit state, `SBOX_PER_CYCLE` columns per clock.
- Uses a valid/ready handshake on both sides.
- Drop-in sequential alternative to the combinational ps inside the permutation datapath, for low-area configurations.

Parameters:
- `SBOX_PER_CYCLE`, 64: S-box instances evaluated per cycle. Legal values: 1, 2, 4, 8, 16, 32, 64. Any other value is an elaboration error.
- `NB_STEP`, 64/`SBOX_PER_CYCLE`: derived; cycles per substitution. Not overridable.

Ports:
- `clock_i`  in  1  system clock, rising edge
- `reset_i`  in  1  synchronous reset, active-high
- `valid_i`  in  1  input state valid
- `ready_o`  out  1  block can accept a state
- `ps_i`  in  type_state (5x64)  state to substitute, x0..x4
- `valid_o`  out  1  `ps_o` holds a completed result
- `ready_i`  in  1  downstream accepts result
- `ps_o`  out  type_state (5x64)  substituted state
- `busy_o`  out  1  substitution in progress

Behaviour:
- Reset: one clock, synchronous, active-high, on `clock_i`; `reset_i` sampled high at a rising edge clears the block.
- Reset values:
  - state = IDLE
  - step counter = 0
  - internal state register = 0
  - `ps_o` = 0
  - `valid_o` = 0
  - `busy_o` = 0
  - `ready_o` = 1 from the first cycle after reset.
- S-box (x0 = MSB of the 5-bit index), table 0..31:
  04 0B 1F 14 1A 15 09 02 1B 05 08 12 1D 03 06 1C 1E 13 07 0E 00 0D 11 18 10 0C 01 19 16 0A 0F 17.
  - Column j input = {x0[j],x1[j],x2[j],x3[j],x4[j]}.
  - Result bits are written back to the same bit j of each word.
- States: IDLE, RUN, DONE.
- IDLE:
  - `ready_o` = 1.
  - On `valid_i`=1, `ps_i` is captured into the state register, counter=0, go to RUN.
- RUN:
  - `busy_o` = 1, `ready_o` = 0.
  - Each cycle, columns [k*N .. k*N+N-1] (N = `SBOX_PER_CYCLE`, k = counter) are substituted in place in the register.
  - Counter increments by 1; on the cycle k = `NB_STEP`-1, counter returns to 0 and go to DONE.
- Latency:
  - Acceptance edge to `valid_o`=1 is exactly `NB_STEP`+1 clock edges (capture edge plus `NB_STEP` compute edges).
  - `SBOX_PER_CYCLE`=64 gives 2; `SBOX_PER_CYCLE`=1 gives 65.
- DONE:
  - `valid_o` = 1; `ps_o` = register contents, held stable while `ready_i`=0 (no change, no timeout).
  - `ready_i`=1 and `valid_i`=0: go to IDLE, `valid_o` falls next cycle.
  - `ready_i`=1 and `valid_i`=1 (simultaneous): `ready_o`=1 combinationally in this case. New `ps_i` is captured on the same edge; go directly to RUN (back-to-back, no IDLE bubble).
- `ps_o` is driven only from the register. It shows partial results during RUN; consumers must qualify with `valid_o`.
- `ready_o` = (state==IDLE) | (state==DONE & `ready_i`). No combinational path from `valid_i` to `ready_o`.
- `valid_i` during RUN is ignored; `ps_i` is not sampled.
- Reset mid-RUN or in DONE aborts immediately. All outputs return to reset values next cycle; the in-flight result is discarded.
- Counter width = max(1, $clog2(`NB_STEP`)).
- Output must equal the combinational ps model bit-for-bit for every `SBOX_PER_CYCLE`.

Test Plan:
1. Reset then all-zero state, `SBOX_PER_CYCLE`=1:
   - `ps_i` = 0 -> after 65 edges, `valid_o`=1.
   - `ps_o` = {0, 0, FFFFFFFFFFFFFFFF, 0, 0}.
   - `busy_o`=1 for exactly 64 cycles.
2. All-ones state, `SBOX_PER_CYCLE`=8:
   - Every word = FFFFFFFFFFFFFFFF -> after 9 edges, `ps_o` = {FFFF.., 0, FFFF.., FFFF.., FFFF..}.
3. Vector {80400c0600000000, 0001020304050607, 08090a0b0c0d0eff, 0011223344556677, 8899aabbccddeeff}:
   - Run for each `SBOX_PER_CYCLE` in {1, 4, 64}.
   - `ps_o` identical across all three and equal to the combinational ps output.
4. Backpressure and back-to-back, `SBOX_PER_CYCLE`=16:
   - Hold `ready_i`=0 for 10 cycles in DONE -> `ps_o`/`valid_o` stable.
   - Then `ready_i`=1 with `valid_i`=1 and all-zero input -> same-edge capture, no IDLE cycle, second result after 5 edges.
5. Reset mid-operation, `SBOX_PER_CYCLE`=1:
   - Assert `reset_i` at step 30 -> next cycle `busy_o`=0, `valid_o`=0, `ps_o`=0, `ready_o`=1.
   - A fresh all-ones run then completes correctly.
6. `valid_i` pulse during RUN with a different `ps_i` -> ignored; the result matches the first captured state only.

Source files
------------

// File: rtl/ps_seq.sv
// Sequential ASCON substitution layer: applies the 5-bit S-box to the 64 bit-columns
// of a 320-bit state, SBOX_PER_CYCLE columns per clock, with valid/ready on both sides.
module ps_seq #(
  parameter  int SBOX_PER_CYCLE = 64,
  localparam int NB_STEP        = 64 / SBOX_PER_CYCLE
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [0:4][63:0] ps_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [0:4][63:0] ps_o,
  output logic             busy_o
);

  localparam int N     = SBOX_PER_CYCLE;
  localparam int CW    = (NB_STEP > 1) ? $clog2(NB_STEP) : 1;
  localparam int LOG_N = $clog2(SBOX_PER_CYCLE);
  localparam logic [CW-1:0] LAST_CNT = CW'(NB_STEP - 1);

  if (!(N == 1 || N == 2 || N == 4 || N == 8 || N == 16 || N == 32 || N == 64)) begin : g_bad_cfg
    $error("ps_seq: SBOX_PER_CYCLE must be one of 1, 2, 4, 8, 16, 32, 64");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [CW-1:0]        cnt_r;
  logic [CW-1:0]        cnt_s;
  logic [0:4][63:0]     data_r;
  logic [0:4][63:0]     data_s;
  logic [5:0]           base_s;
  logic [0:4][N-1:0]    col_in_s;
  logic [0:4][N-1:0]    col_out_s;
  logic                 ready_s;

  // Bitsliced ASCON S-box over N columns; word 0 carries x0 (index MSB).
  function automatic logic [0:4][N-1:0] sbox_cols(input logic [0:4][N-1:0] x);
    logic [N-1:0] a0, a1, a2, a3, a4;
    logic [N-1:0] t0, t1, t2, t3, t4;
    a0 = x[0] ^ x[4];
    a1 = x[1];
    a2 = x[2] ^ x[1];
    a3 = x[3];
    a4 = x[4] ^ x[3];
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    a0 = a0 ^ t1;
    a1 = a1 ^ t2;
    a2 = a2 ^ t3;
    a3 = a3 ^ t4;
    a4 = a4 ^ t0;
    a1 = a1 ^ a0;
    a0 = a0 ^ a4;
    a3 = a3 ^ a2;
    a2 = ~a2;
    return {a0, a1, a2, a3, a4};
  endfunction

  // Accept from IDLE, or from DONE when the result is being consumed this edge.
  assign ready_s = (state_r == IDLE) || ((state_r == DONE) && ready_i);

  // Column window of the current step and its substituted value.
  always_comb begin
    base_s = 6'(cnt_r) << LOG_N;
    for (int i = 0; i < 5; i++) begin
      col_in_s[i] = data_r[i][base_s +: N];
    end
    col_out_s = sbox_cols(col_in_s);
  end

  // Next-state, counter and in-place state register update.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    data_s  = data_r;
    case (state_r)
      IDLE: begin
        if (valid_i) begin
          data_s  = ps_i;
          cnt_s   = {CW{1'b0}};
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        for (int i = 0; i < 5; i++) begin
          data_s[i][base_s +: N] = col_out_s[i];
        end
        if (cnt_r == LAST_CNT) begin
          cnt_s   = {CW{1'b0}};
          state_s = DONE;
        end else begin
          cnt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
          state_s = RUN;
        end
      end
      DONE: begin
        if (ready_i) begin
          if (valid_i) begin
            // Back-to-back: the next state is captured on the consuming edge.
            data_s  = ps_i;
            cnt_s   = {CW{1'b0}};
            state_s = RUN;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // State, counter and data registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      data_r  <= {320{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      data_r  <= data_s;
    end
  end

  assign ready_o = ready_s;
  assign valid_o = (state_r == DONE);
  assign busy_o  = (state_r == RUN);
  assign ps_o    = data_r;

endmodule

// File: tb/tb_ps_seq.sv
// Self-checking bench for ps_seq: five instances (1/4/8/16/64 S-boxes per cycle)
// compared against a table-driven substitution model.
module tb_ps_seq;

  typedef logic [0:4][63:0] st_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] reset_v;
  logic [4:0] valid_iv;
  logic [4:0] ready_iv;
  logic [4:0] ready_v;
  logic [4:0] valid_v;
  logic [4:0] busy_v;
  st_t        psi_a [5];
  st_t        pso_a [5];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [4:0] sbox_tab [32] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
  };

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int SPC = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : (g == 3) ? 16 : 64;
    ps_seq #(.SBOX_PER_CYCLE(SPC)) u_dut (
      .clock_i (clk),
      .reset_i (reset_v[g]),
      .valid_i (valid_iv[g]),
      .ready_o (ready_v[g]),
      .ps_i    (psi_a[g]),
      .valid_o (valid_v[g]),
      .ready_i (ready_iv[g]),
      .ps_o    (pso_a[g]),
      .busy_o  (busy_v[g])
    );
  end

  function automatic int nb_of(input int d);
    case (d)
      0: return 64;
      1: return 16;
      2: return 8;
      3: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic st_t model_ps(input st_t s);
    st_t r;
    logic [4:0] idx;
    logic [4:0] o;
    for (int j = 0; j < 64; j++) begin
      idx = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
      o = sbox_tab[idx];
      r[0][j] = o[4];
      r[1][j] = o[3];
      r[2][j] = o[2];
      r[3][j] = o[1];
      r[4][j] = o[0];
    end
    return r;
  endfunction

  function automatic st_t rand_state();
    st_t s;
    for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
    return s;
  endfunction

  // Present a state for one edge; returns #1 after the acceptance edge.
  task automatic start(input int d, input st_t s);
    valid_iv[d] = 1'b1;
    psi_a[d] = s;
    @(posedge clk); #1;
    valid_iv[d] = 1'b0;
    psi_a[d] = ~s;
  endtask

  // Wait (bounded) for valid_o; edges counts from the acceptance edge.
  task automatic wait_done(input int d, input int e0, output int edges, output int busy);
    edges = e0;
    busy = 0;
    while (valid_v[d] !== 1'b1 && edges < 200) begin
      if (busy_v[d] === 1'b1) busy++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic release_result(input int d);
    ready_iv[d] = 1'b1;
    @(posedge clk); #1;
    ready_iv[d] = 1'b0;
  endtask

  task automatic test_reset();
    reset_v = 5'b11111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_v = 5'b00000;
    for (int d = 0; d < 5; d++) begin
      n_cmp++;
      if (valid_v[d] !== 1'b0 || busy_v[d] !== 1'b0 || ready_v[d] !== 1'b1 || pso_a[d] !== '0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got valid=%b busy=%b ready=%b ps=%h want 0 0 1 0",
                 d, valid_v[d], busy_v[d], ready_v[d], pso_a[d]);
      end
    end
  endtask

  task automatic test_zero();
    st_t z;
    st_t exp_s;
    int edges;
    int busy;
    z = '0;
    exp_s = {64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0};
    start(0, z);
    wait_done(0, 1, edges, busy);
    n_cmp++;
    if (edges !== 65) begin n_fail++; $display("FAIL zero_latency: got %0d want 65", edges); end
    n_cmp++;
    if (busy !== 64) begin n_fail++; $display("FAIL zero_busy: got %0d want 64", busy); end
    n_cmp++;
    if (pso_a[0] !== exp_s) begin n_fail++; $display("FAIL zero_result: got %h want %h", pso_a[0], exp_s); end
    n_cmp++;
    if (pso_a[0] !== model_ps(z)) begin n_fail++; $display("FAIL zero_model: got %h want %h", pso_a[0], model_ps(z)); end
    release_result(0);
    n_cmp++;
    if (valid_v[0] !== 1'b0 || ready_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_release: got valid=%b ready=%b want 0 1", valid_v[0], ready_v[0]);
    end
  endtask

  task automatic test_ones();
    st_t s;
    st_t exp_s;
    int edges;
    int busy;
    s = '1;
    exp_s = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    start(2, s);
    wait_done(2, 1, edges, busy);
    n_cmp++;
    if (edges !== 9) begin n_fail++; $display("FAIL ones_latency: got %0d want 9", edges); end
    n_cmp++;
    if (pso_a[2] !== exp_s) begin n_fail++; $display("FAIL ones_result: got %h want %h", pso_a[2], exp_s); end
    release_result(2);
  endtask

  task automatic test_vector();
    st_t v;
    st_t r [3];
    int ids [3];
    int edges;
    int busy;
    ids = '{0, 1, 4};
    v = {64'h80400c0600000000, 64'h0001020304050607, 64'h08090a0b0c0d0eff,
         64'h0011223344556677, 64'h8899aabbccddeeff};
    for (int k = 0; k < 3; k++) begin
      start(ids[k], v);
      wait_done(ids[k], 1, edges, busy);
      r[k] = pso_a[ids[k]];
      n_cmp++;
      if (edges !== nb_of(ids[k]) + 1) begin
        n_fail++;
        $display("FAIL vector_latency[%0d]: got %0d want %0d", ids[k], edges, nb_of(ids[k]) + 1);
      end
      n_cmp++;
      if (r[k] !== model_ps(v)) begin
        n_fail++;
        $display("FAIL vector_result[%0d]: got %h want %h", ids[k], r[k], model_ps(v));
      end
      release_result(ids[k]);
    end
    n_cmp++;
    if (r[0] !== r[1] || r[1] !== r[2]) begin
      n_fail++;
      $display("FAIL vector_agree: got %h / %h want %h", r[1], r[2], r[0]);
    end
  endtask

  task automatic test_random();
    st_t s;
    int edges;
    int busy;
    for (int rep = 0; rep < 3; rep++) begin
      for (int d = 0; d < 5; d++) begin
        s = rand_state();
        start(d, s);
        wait_done(d, 1, edges, busy);
        n_cmp++;
        if (edges !== nb_of(d) + 1 || pso_a[d] !== model_ps(s)) begin
          n_fail++;
          $display("FAIL random[%0d]: got lat=%0d ps=%h want lat=%0d ps=%h",
                   d, edges, pso_a[d], nb_of(d) + 1, model_ps(s));
        end
        release_result(d);
      end
    end
  endtask

  task automatic test_back_to_back();
    st_t s;
    st_t held;
    st_t z;
    int edges;
    int busy;
    z = '0;
    s = rand_state();
    start(3, s);
    wait_done(3, 1, edges, busy);
    held = pso_a[3];
    n_cmp++;
    if (edges !== 5 || held !== model_ps(s)) begin
      n_fail++;
      $display("FAIL b2b_first: got lat=%0d ps=%h want lat=5 ps=%h", edges, held, model_ps(s));
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (valid_v[3] !== 1'b1 || pso_a[3] !== held) begin
        n_fail++;
        $display("FAIL b2b_hold[%0d]: got valid=%b ps=%h want 1 %h", c, valid_v[3], pso_a[3], held);
      end
    end
    ready_iv[3] = 1'b1;
    valid_iv[3] = 1'b1;
    psi_a[3] = z;
    #1;
    n_cmp++;
    if (ready_v[3] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", ready_v[3]); end
    @(posedge clk); #1;
    ready_iv[3] = 1'b0;
    valid_iv[3] = 1'b0;
    psi_a[3] = rand_state();
    n_cmp++;
    if (busy_v[3] !== 1'b1 || valid_v[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_bubble: got busy=%b valid=%b want 1 0", busy_v[3], valid_v[3]);
    end
    wait_done(3, 1, edges, busy);
    n_cmp++;
    if (edges !== 5 || pso_a[3] !== model_ps(z)) begin
      n_fail++;
      $display("FAIL b2b_second: got lat=%0d ps=%h want lat=5 ps=%h", edges, pso_a[3], model_ps(z));
    end
    release_result(3);
  endtask

  task automatic test_reset_mid();
    st_t s;
    st_t exp_s;
    int edges;
    int busy;
    start(0, rand_state());
    repeat (30) begin @(posedge clk); #1; end
    n_cmp++;
    if (busy_v[0] !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before: got %b want 1", busy_v[0]); end
    reset_v[0] = 1'b1;
    @(posedge clk); #1;
    reset_v[0] = 1'b0;
    n_cmp++;
    if (busy_v[0] !== 1'b0 || valid_v[0] !== 1'b0 || pso_a[0] !== '0 || ready_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_state: got busy=%b valid=%b ready=%b ps=%h want 0 0 1 0",
               busy_v[0], valid_v[0], ready_v[0], pso_a[0]);
    end
    s = '1;
    exp_s = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    start(0, s);
    wait_done(0, 1, edges, busy);
    n_cmp++;
    if (edges !== 65 || pso_a[0] !== exp_s) begin
      n_fail++;
      $display("FAIL midreset_rerun: got lat=%0d ps=%h want lat=65 ps=%h", edges, pso_a[0], exp_s);
    end
    release_result(0);
  endtask

  task automatic test_valid_during_run();
    st_t s1;
    st_t s2;
    int edges;
    int busy;
    s1 = rand_state();
    s2 = rand_state();
    start(1, s1);
    valid_iv[1] = 1'b1;
    psi_a[1] = s2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    valid_iv[1] = 1'b0;
    wait_done(1, 3, edges, busy);
    n_cmp++;
    if (edges !== 17 || pso_a[1] !== model_ps(s1)) begin
      n_fail++;
      $display("FAIL ignore_valid: got lat=%0d ps=%h want lat=17 ps=%h", edges, pso_a[1], model_ps(s1));
    end
    release_result(1);
    n_cmp++;
    if (ready_v[1] !== 1'b1 || valid_v[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_valid_idle: got ready=%b valid=%b want 1 0", ready_v[1], valid_v[1]);
    end
  endtask

  initial begin
    reset_v  = 5'b00000;
    valid_iv = 5'b00000;
    ready_iv = 5'b00000;
    for (int d = 0; d < 5; d++) psi_a[d] = '0;
    test_reset();
    test_zero();
    test_ones();
    test_vector();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_valid_during_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
